// File: rtl/output_stream_buffer.sv
// Slot buffer with random read access and an ordered flush stream of the valid slots.
// Slots are written by index; a flush walks ptr upward and streams each valid slot once.
module output_stream_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_hit,
  input  logic              clr,
  input  logic              flush_start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              done,
  output logic [IDX_W:0]    count,
  output logic [1:0]        dbg_state
);

  // Stream handshake: a slot transfers on a rising edge where out_valid && out_ready;
  // out_valid, out_data and out_index are held stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_hit_q;
  logic [IDX_W:0]    count_q, count_d;
  logic              wr_ok, hs, wr_new, clr_slot;

  assign wr_ok    = wr_en && !clr;
  assign hs       = (state_q == SEND) && out_ready;
  assign wr_new   = wr_ok && !valid_q[wr_index];
  // A same-cycle write to the slot being handed off keeps it valid with the new data.
  assign clr_slot = hs && !(wr_ok && (wr_index == ptr_q));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    valid_d     = valid_q;
    count_d     = count_q;
    if (clr) begin
      valid_d = '0;
      count_d = '0;
      state_d = IDLE;
    end else begin
      if (clr_slot) valid_d[ptr_q] = 1'b0;
      if (wr_ok) valid_d[wr_index] = 1'b1;
      count_d = count_q + (IDX_W+1)'(wr_new) - (IDX_W+1)'(clr_slot);
      case (state_q)
        IDLE: begin
          if (flush_start) begin
            ptr_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (valid_q[ptr_q]) begin
            out_data_d  = mem_q[ptr_q];
            out_index_d = ptr_q;
            state_d     = SEND;
          end else if (ptr_q == LAST) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (ptr_q == LAST) begin
              state_d = DONE;
            end else begin
              ptr_d   = ptr_q + IDX_W'(1);
              state_d = SCAN;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      valid_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
    end
  end

  // Slot data is never reset; the valid bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_index] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else if (rd_en) begin
      rd_data_q <= valid_q[rd_index] ? mem_q[rd_index] : '0;
      rd_hit_q  <= valid_q[rd_index];
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_hit    = rd_hit_q;
  assign busy      = (state_q == SCAN) || (state_q == SEND);
  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_output_stream_buffer.sv
// Bench for output_stream_buffer: directed reads/writes plus flushes checked
// against an expected-stream queue filled as slots are written.
module tb_output_stream_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;
  localparam int EW     = IDX_W + DATA_W;

  logic              clk, rst_n;
  logic              wr_en, rd_en, clr, flush_start, out_ready;
  logic [IDX_W-1:0]  wr_index, rd_index;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data, out_data;
  logic              rd_hit, busy, out_valid, done;
  logic [IDX_W-1:0]  out_index;
  logic [IDX_W:0]    count;
  logic [1:0]        dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks, n_errors;
  int done_cnt, valid_cycles;

  output_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data), .rd_hit(rd_hit),
    .clr(clr), .flush_start(flush_start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .done(done), .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // stream scoreboard and done/valid monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream_extra", 32'(exp_q.size()), 32'd1);
        else check("stream", 32'({out_index, out_data}), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
      if (out_valid) valid_cycles++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int idx, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_index = IDX_W'(idx); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input int idx, input logic [DATA_W-1:0] ed, input logic eh);
    rd_en = 1'b1; rd_index = IDX_W'(idx);
    step();
    rd_en = 1'b0;
    check({tag, "_data"}, 32'(rd_data), 32'(ed));
    check({tag, "_hit"}, 32'(rd_hit), 32'(eh));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic start_flush();
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    if (!out_valid) check({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  // returns the number of cycles from the flush_start cycle to done
  task automatic flush_to_done(input string tag, output int cycles);
    int d0 = done_cnt;
    start_flush();
    cycles = 1;
    while (!done && cycles < 500) begin step(); cycles++; end
    if (!done) check({tag, "_done_timeout"}, 32'(done), 32'd1);
    step();
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc, v0, d0;
    logic [DATA_W-1:0] da, db, d1, d5, d31;
    logic [DATA_W-1:0] hold_d;
    logic [IDX_W-1:0]  hold_i;

    n_checks = 0; n_errors = 0; done_cnt = 0; valid_cycles = 0;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; flush_start = 1'b0;
    out_ready = 1'b0; wr_index = '0; rd_index = '0; wr_data = '0;
    step(); step();
    check("rst_count", 32'(count), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_hit", 32'(rd_hit), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_index", 32'(out_index), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    step();

    // random read, empty read, read-before-write
    do_write(3, 8'hA5);
    do_read("rd3", 3, 8'hA5, 1'b1);
    do_read("rd4", 4, 8'h00, 1'b0);
    check("count_one", 32'(count), 1);
    rd_en = 1'b1; rd_index = 5'd3; wr_en = 1'b1; wr_index = 5'd3; wr_data = 8'h5A;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rbw_old", 32'(rd_data), 32'h0A5);
    check("rd_hold", 32'(rd_data), 32'h0A5);
    do_read("rbw_new", 3, 8'h5A, 1'b1);
    do_clr();
    check("clr_count", 32'(count), 0);
    do_read("rd_after_clr", 3, 8'h00, 1'b0);

    // three slots streamed in ascending order
    d1 = 8'($urandom_range(0, 255)); d5 = 8'($urandom_range(0, 255)); d31 = 8'($urandom_range(0, 255));
    do_write(31, d31); do_write(1, d1); do_write(5, d5);
    exp_q.push_back({5'd1, d1}); exp_q.push_back({5'd5, d5}); exp_q.push_back({5'd31, d31});
    check("count_three", 32'(count), 3);
    out_ready = 1'b1;
    flush_to_done("f3", cyc);
    check("f3_count_end", 32'(count), 0);
    check("f3_q_empty", 32'(exp_q.size()), 0);

    // back-pressure: out_ready low for 4 cycles on slot 5
    da = 8'($urandom_range(1, 254));
    do_write(5, da);
    exp_q.push_back({5'd5, da});
    out_ready = 1'b0;
    start_flush();
    wait_valid("bp");
    hold_d = out_data; hold_i = out_index;
    check("bp_index", 32'(out_index), 5);
    check("bp_data", 32'(out_data), 32'(da));
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_data", 32'(out_data), 32'(hold_d));
      check("bp_hold_index", 32'(out_index), 32'(hold_i));
    end
    out_ready = 1'b1;
    step();
    check("bp_xfer_drop", 32'(out_valid), 0);
    check("bp_q_empty", 32'(exp_q.size()), 0);
    cyc = 0;
    while (!done && cyc < 100) begin step(); cyc++; end
    check("bp_done", 32'(done), 1);
    step();

    // writes ahead of and behind ptr during a flush
    da = 8'($urandom_range(0, 255)); db = 8'($urandom_range(0, 255));
    do_write(10, 8'h3C);
    exp_q.push_back({5'd10, 8'h3C});
    out_ready = 1'b0;
    start_flush();
    wait_valid("mid");
    check("mid_index", 32'(out_index), 10);
    do_write(2, da);
    do_write(20, db);
    exp_q.push_back({5'd20, db});
    out_ready = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin step(); cyc++; end
    check("mid_done", 32'(done), 1);
    step();
    check("mid_count", 32'(count), 1);
    check("mid_q_empty", 32'(exp_q.size()), 0);
    do_read("mid_rd2", 2, da, 1'b1);
    do_read("mid_rd20", 20, 8'h00, 1'b0);
    do_clr();

    // write to the slot being sent, in the handshake cycle
    do_write(7, 8'h11);
    exp_q.push_back({5'd7, 8'h11});
    out_ready = 1'b0;
    start_flush();
    wait_valid("wsend");
    wr_en = 1'b1; wr_index = 5'd7; wr_data = 8'h99; out_ready = 1'b1;
    step();
    wr_en = 1'b0;
    check("wsend_count", 32'(count), 1);
    check("wsend_q_empty", 32'(exp_q.size()), 0);
    cyc = 0;
    while (!done && cyc < 100) begin step(); cyc++; end
    step();
    do_read("wsend_rd7", 7, 8'h99, 1'b1);
    do_clr();

    // clr while in SEND
    do_write(9, 8'h42);
    out_ready = 1'b0;
    start_flush();
    wait_valid("clrsend");
    d0 = done_cnt;
    do_clr();
    check("clrsend_valid", 32'(out_valid), 0);
    check("clrsend_busy", 32'(busy), 0);
    check("clrsend_count", 32'(count), 0);
    step(); step(); step();
    check("clrsend_no_done", 32'(done_cnt - d0), 0);
    exp_q.delete();

    // reset while in SEND
    do_write(9, 8'h42);
    start_flush();
    wait_valid("rstsend");
    d0 = done_cnt;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstsend_valid", 32'(out_valid), 0);
    check("rstsend_busy", 32'(busy), 0);
    check("rstsend_count", 32'(count), 0);
    step(); step(); step();
    check("rstsend_no_done", 32'(done_cnt - d0), 0);
    exp_q.delete();

    // empty flush: done DEPTH+1 cycles after flush_start
    out_ready = 1'b1;
    v0 = valid_cycles;
    flush_to_done("empty", cyc);
    check("empty_latency", 32'(cyc), 33);
    check("empty_no_valid", 32'(valid_cycles - v0), 0);

    check("final_q_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/output_stream_buffer.md
OUTPUT_STREAM_BUFFER -- requirements
Module: output_stream_buffer

Interface
REQ-001 Parameter DATA_W, default 8, slot data width in bits.
REQ-002 Parameter DEPTH, default 32, number of slots; power of two, minimum 2.
REQ-003 Parameter IDX_W, default $clog2(DEPTH), slot index width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 wr_en  in  1  write strobe for slot wr_index.
REQ-007 wr_index  in  IDX_W  write slot address.
REQ-008 wr_data  in  DATA_W  write data, typically the accumulator value.
REQ-009 rd_en  in  1  random-read request.
REQ-010 rd_index  in  IDX_W  random-read slot address.
REQ-011 rd_data  out  DATA_W  registered random-read data.
REQ-012 rd_hit  out  1  registered flag: the slot that was read held valid data.
REQ-013 clr  in  1  clears all slot-valid bits.
REQ-014 flush_start  in  1  starts streaming all valid slots in ascending index order.
REQ-015 busy  out  1  high while a flush is in progress.
REQ-016 out_valid  out  1  stream data valid.
REQ-017 out_ready  in  1  stream sink ready.
REQ-018 out_data  out  DATA_W  stream data.
REQ-019 out_index  out  IDX_W  slot index of out_data.
REQ-020 done  out  1  one-cycle pulse when a flush completes.
REQ-021 count  out  IDX_W+1  number of valid slots, range 0..DEPTH.

Function
REQ-022 Each slot SHALL hold DATA_W data bits and one valid bit; wr_en SHALL store wr_data in the slot and set its valid bit on the next edge.
REQ-023 rd_en SHALL register rd_data as the slot data if the slot is valid, else 0, and SHALL set rd_hit to the slot valid bit; latency is 1 cycle; rd_data and rd_hit SHALL hold their values when rd_en is low.
REQ-024 A read and a write to the same slot in the same cycle SHALL return the old contents (read-before-write).
REQ-025 The FSM SHALL have states IDLE, SCAN, SEND and DONE; busy SHALL be high in SCAN and SEND.
REQ-026 IDLE: flush_start SHALL set ptr=0 and go to SCAN; flush_start outside IDLE SHALL be ignored.
REQ-027 SCAN: if slot[ptr] is valid, the block SHALL latch its data into out_data, set out_index=ptr, set out_valid and go to SEND; otherwise, if ptr==DEPTH-1 it SHALL go to DONE, else ptr SHALL increment. Each SCAN step takes one cycle per slot.
REQ-028 SEND: out_valid, out_data and out_index SHALL stay stable until out_valid&&out_ready.
REQ-029 On the SEND handshake, the block SHALL clear slot[ptr] valid and drop out_valid; it SHALL go to DONE if ptr==DEPTH-1, else increment ptr and return to SCAN.
REQ-030 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-031 A flush with no valid slots SHALL complete in DEPTH SCAN cycles followed by a done pulse.
REQ-032 Writes SHALL be accepted in every state.
REQ-033 A write to an index greater than ptr during a flush SHALL be streamed in that flush.
REQ-034 A write to an index less than ptr during a flush SHALL stay valid and SHALL NOT be streamed.
REQ-035 A write to slot ptr while in SEND SHALL NOT alter the latched out_data; the write SHALL take priority over the handshake clear, so the slot stays valid with the new data.
REQ-036 clr SHALL have priority over every other operation: it clears all valid bits and, if a flush is in progress, forces IDLE with out_valid=0 and no done pulse; a write in the same cycle as clr SHALL be discarded.
REQ-037 count SHALL be updated in the cycle of the change: +1 on a write to an invalid slot, -1 on a handshake clear, unchanged when both occur in the same cycle, 0 on clr.
REQ-038 count SHALL never exceed DEPTH or fall below 0.

Reset
REQ-039 When rst_n=0 at a clock edge, the block SHALL clear all valid bits and set count=0, rd_data=0, rd_hit=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0, ptr=0 and state=IDLE.
REQ-040 Reset SHALL abort any flush in progress with no done pulse; slot data contents need not be reset.

Verification
REQ-041 Write 0xA5 to slot 3, then rd_en at index 3 -> the next cycle rd_data=0xA5, rd_hit=1; a read of empty slot 4 -> rd_data=0, rd_hit=1'b0.
REQ-042 Slots 1, 5 and 31 valid, flush with out_ready=1 -> out_index sequence 1, 5, 31; done pulses once; count goes 3->0; busy is low after DONE.
REQ-043 Flush with out_ready held low for 4 cycles on slot 5 -> out_valid, out_data and out_index stay stable for 4 cycles; the transfer occurs on the cycle ready rises.
REQ-044 During a flush at ptr=10, write slot 2 and slot 20 -> slot 20 is streamed; slot 2 stays valid; count ends at 1.
REQ-045 clr asserted in SEND -> the next cycle out_valid=0, busy=0, count=0 and no done pulse; rst_n low mid-flush gives the same result.
REQ-046 Empty buffer with flush_start at DEPTH=32 -> done asserts exactly 33 cycles after flush_start with no out_valid.
